dmem_responder: RTL and testbench

Responder-side data memory for the RISC-V core's load/store port. It accepts one request at a time over a valid/ready handshake, inserts a parameterised number of wait states, and performs byte, halfword or word stores and loads with sign or zero extension. It returns a registered response with an error flag. It sits behind the core's memory stage and gives the core a realistic, stallable memory target in place of a zero-latency array.

---
 rtl/dmem_responder.sv | 183 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Stallable data memory for the core load/store port: one request in flight, byte/half/word access with sign/zero extend.
// Latency WAIT_CYCLES+1 from acceptance to rsp_valid; access happens at acceptance edge + WAIT_CYCLES.
// Backpressure: RESP holds registered outputs until rsp_ready; req_ready only in IDLE. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        w_accept, w_access;

    logic        r_write, r_unsigned;
    logic [31:0] r_addr, r_wdata;
    logic [2:0]  r_size;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_a_write, w_a_uns;
    logic [31:0] w_a_addr, w_a_wdata;
    logic [2:0]  w_a_size;
    logic        w_size_bad, w_range_bad, w_misalign, w_err;
    logic [1:0]  w_off;
    logic [AW-1:0] w_idx;
    logic [31:0] w_rd_word, w_wr_word, w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_be;

    // With zero wait states the access happens on the acceptance edge, so it must use the live request.
    always_comb begin
        w_a_write = r_write;
        w_a_addr  = r_addr;
        w_a_wdata = r_wdata;
        w_a_size  = r_size;
        w_a_uns   = r_unsigned;
        if (r_state == S_IDLE) begin
            w_a_write = req_write;
            w_a_addr  = req_addr;
            w_a_wdata = req_wdata;
            w_a_size  = req_size;
            w_a_uns   = req_unsigned;
        end
    end

    always_comb begin
        w_size_bad  = (w_a_size > 3'd2);
        w_range_bad = ({1'b0, w_a_addr} >= ADDR_LIMIT);
`ifdef DMEM_MISALIGN_TRAP_EN
        w_misalign  = ((w_a_size == 3'd1) && w_a_addr[0]) ||
                      ((w_a_size == 3'd2) && (w_a_addr[1:0] != 2'b00));
`else
        w_misalign  = 1'b0;
`endif
        w_err = w_size_bad || w_range_bad || w_misalign;

        w_off = 2'b00;
        w_be  = 4'b1111;
        w_wr_word = w_a_wdata;
        if (w_a_size == 3'd0) begin
            w_off     = w_a_addr[1:0];
            w_be      = 4'b0001 << w_a_addr[1:0];
            w_wr_word = {4{w_a_wdata[7:0]}};
        end else if (w_a_size == 3'd1) begin
            w_off     = {w_a_addr[1], 1'b0};
            w_be      = w_a_addr[1] ? 4'b1100 : 4'b0011;
            w_wr_word = {2{w_a_wdata[15:0]}};
        end

        w_idx     = w_a_addr[2 +: AW];
        w_rd_word = r_mem[w_idx];
        w_byte    = w_rd_word[{w_off, 3'b000} +: 8];
        w_half    = w_rd_word[{w_off[1], 4'b0000} +: 16];
        case (w_a_size)
            3'd0:    w_load = w_a_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load = w_a_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_rd_word;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (WAIT_INIT == 4'd0) begin
                        w_access    = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_cnt_nxt   = WAIT_INIT;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_size      <= 3'd0;
            r_unsigned  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write    <= req_write;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
            end
            if (w_access) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || w_a_write) ? 32'd0 : w_load;
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= 32'd0;
            end
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_access && w_a_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= w_wr_word[i*8 +: 8];
                end
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of single transactions on a 2-wait-state instance,
// plus hand sequences for backpressure and mid-transaction reset on a 3-wait-state instance.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [2:0]  req_size = 3'd0;

    logic        rdy2, vld2, err2, rdy3, vld3, err3;
    logic [31:0] rd2, rd3;
    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rdy2),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned), .rsp_valid(vld2),
        .rsp_ready(rsp_ready & ~sel), .rsp_rdata(rd2), .rsp_err(err2));

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rdy3),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned), .rsp_valid(vld3),
        .rsp_ready(rsp_ready & sel), .rsp_rdata(rd3), .rsp_err(err3));

    assign m_req_ready = sel ? rdy3 : rdy2;
    assign m_rsp_valid = sel ? vld3 : vld2;
    assign m_rsp_rdata = sel ? rd3  : rd2;
    assign m_rsp_err   = sel ? err3 : err2;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  sz;
        logic        un;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] sz, input logic un);
        req_write = wr; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = un;
    endtask

    // Returns number of negedges from the acceptance cycle to the first rsp_valid sample.
    task automatic wait_rsp(output int lat);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!m_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_req(input string nm, input vec_t v);
        int k;
        int lat;
        @(negedge clk);
        set_req(v.wr, v.addr, v.wd, v.sz, v.un);
        req_valid = 1'b1;
        k = 0;
        while (!m_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        wait_rsp(lat);
        check({nm, "_latency"}, 32'(lat), sel ? 32'd4 : 32'd3);
        check({nm, "_rdata"}, m_rsp_rdata, v.exp_d);
        check({nm, "_err"}, 32'(m_rsp_err), 32'(v.exp_e));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_req_ready"}, 32'(m_req_ready), 32'd1);
        check({nm, "_rsp_valid"}, 32'(m_rsp_valid), 32'd0);
        check({nm, "_rsp_rdata"}, m_rsp_rdata, 32'd0);
        check({nm, "_rsp_err"}, 32'(m_rsp_err), 32'd0);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 3'd2, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'd2, 1'b0, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         3'd2, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0013, 32'hFFFF_FF80, 3'd0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0013, 32'h0,         3'd0, 1'b0, 32'hFFFF_FF80, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0,         3'd0, 1'b1, 32'h0000_0080, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         3'd2, 1'b0, 32'h80AD_BEEF, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs[7]  = '{1'b0, 32'h0000_0011, 32'h0,         3'd1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0013, 32'h0,         3'd2, 1'b0, 32'h0000_0000, 1'b1};
`else
        vecs[7]  = '{1'b0, 32'h0000_0011, 32'h0,         3'd1, 1'b0, 32'hFFFF_BEEF, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0013, 32'h0,         3'd2, 1'b0, 32'h80AD_BEEF, 1'b0};
`endif
        vecs[8]  = '{1'b0, 32'h0000_0012, 32'h0,         3'd1, 1'b1, 32'h0000_80AD, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0012, 32'h0,         3'd1, 1'b0, 32'hFFFF_80AD, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_1000, 32'h1111_1111, 3'd2, 1'b0, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         3'd2, 1'b0, 32'hA5A5_A5A5, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         3'd3, 1'b0, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b1, 32'h0000_0010, 32'h0,         3'd3, 1'b0, 32'h0000_0000, 1'b1};
        vecs[15] = '{1'b0, 32'h0000_0010, 32'h0,         3'd2, 1'b0, 32'h80AD_BEEF, 1'b0};
        vecs[16] = '{1'b1, 32'h0000_0002, 32'hABCD_1234, 3'd1, 1'b0, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b0, 32'h0000_0000, 32'h0,         3'd2, 1'b0, 32'h1234_A5A5, 1'b0};
        vecs[18] = '{1'b0, 32'h0000_0003, 32'h0,         3'd0, 1'b0, 32'h0000_0012, 1'b0};
        vecs[19] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 3'd2, 1'b0, 32'h0000_0000, 1'b0};
        vecs[20] = '{1'b0, 32'h0000_0FFC, 32'h0,         3'd2, 1'b0, 32'h0BAD_CAFE, 1'b0};
        vecs[21] = '{1'b1, 32'h0000_1003, 32'h0000_0077, 3'd0, 1'b0, 32'h0000_0000, 1'b1};

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        for (int i = 0; i < 22; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: response held for 5 cycles while the next request waits.
        @(negedge clk);
        set_req(1'b0, 32'h10, 32'h0, 3'd2, 1'b0);
        req_valid = 1'b1;
        wait_rsp(lat);
        check("bp_first_latency", 32'(lat), 32'd3);
        set_req(1'b0, 32'h13, 32'h0, 3'd0, 1'b1);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", i), 32'(m_rsp_valid), 32'd1);
            check($sformatf("bp_hold%0d_rdata", i), m_rsp_rdata, 32'h80AD_BEEF);
            check($sformatf("bp_hold%0d_req_ready", i), 32'(m_req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_idle_req_ready", 32'(m_req_ready), 32'd1);
        check("bp_idle_rsp_valid", 32'(m_rsp_valid), 32'd0);
        wait_rsp(lat);
        check("bp_second_latency", 32'(lat), 32'd3);
        check("bp_second_rdata", m_rsp_rdata, 32'h0000_0080);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset in the middle of a 3-wait-state store discards it.
        sel = 1'b1;
        do_req("w3_store_old", '{1'b1, 32'h20, 32'hCAFE_F00D, 3'd2, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        set_req(1'b1, 32'h20, 32'h1234_5678, 3'd2, 1'b0);
        req_valid = 1'b1;
        check("w3_accept_ready", 32'(m_req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("w3_in_wait", 32'(m_req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("w3_mid_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("w3_after_reset");
        do_req("w3_load_old", '{1'b0, 32'h20, 32'h0, 3'd2, 1'b0, 32'hCAFE_F00D, 1'b0});

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
